alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
Iterative unsigned multiply sequencer attached beside the ALU stage. It accepts one MUL request (ra*rb), runs a shift-add datapath for a fixed number of steps, then presents a writeback-ready result with an overflow flag. Overflow follows ALU add semantics: the high half of the 64-bit product is nonzero. While busy it back-pressures the decode/ALU issue path through req_ready. Flush discards any in-flight operation.

Parameters:
DATA_W, 32, operand and result width; product width is 2*DATA_W.
ID_W, 3, ROB instruction id width; matches rob_tail width.
STEP_BITS, 1, multiplier bits retired per RUN cycle; must divide DATA_W; STEPS = DATA_W/STEP_BITS.

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush; same source as flush_alu
req_valid  in  1  MUL request present
req_ready  out  1  sequencer can accept; high only in IDLE
req_instr_id  in  ID_W  ROB id of request
req_rd  in  5  destination register
req_src1  in  DATA_W  multiplicand (ra_data after ROB bypass)
req_src2  in  DATA_W  multiplier (rb_data after ROB bypass)
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts result
resp_instr_id  out  ID_W  captured ROB id
resp_rd  out  5  captured destination
resp_data  out  DATA_W  product[DATA_W-1:0]
resp_ovf  out  1  product[2*DATA_W-1:DATA_W] != 0
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, accumulator=0. Outputs: req_ready=1, resp_valid=0, busy=0, resp_instr_id/resp_rd/resp_data/resp_ovf=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid & !flush at clock edge, latch id/rd, mcand={DATA_W'0,src1} (2*DATA_W wide), mplier=src2, acc=0, count=0; go to RUN.
- RUN, each cycle:
  - acc += mcand * mplier[STEP_BITS-1:0] (2*DATA_W wide, no truncation before final split).
  - mcand <<= STEP_BITS; mplier >>= STEP_BITS; count++.
  - When count==STEPS-1 at the edge, go to DONE with final acc.
- RUN lasts exactly STEPS cycles. resp_valid rises STEPS cycles after the accepting edge; this is 32 with the defaults.
- DONE:
  - resp_valid=1; resp_data=acc[DATA_W-1:0]; resp_ovf=|acc[2*DATA_W-1:DATA_W].
  - All resp_* fields are stable while resp_valid=1.
  - On resp_ready go to IDLE. resp_ready may be held low indefinitely.
- No acceptance in the DONE->IDLE cycle: req_ready is a pure function of state (registered); there is no combinational path req_valid->req_ready.
- Flush:
  - Any state goes to IDLE next edge; resp_valid=0 next cycle and the result is dropped.
  - flush has priority over req_valid and resp_ready.
  - If flush and resp_ready coincide in DONE, IDLE is entered and the result counts as not consumed.
- resp_* values after leaving DONE retain their last value but are meaningless.
- Arithmetic is unsigned only. Zero operands still take STEPS cycles, unless the optional feature is enabled.
- req_* inputs are ignored whenever req_ready=0.

Optional Feature:
Macro MUL_EARLY_OUT_EN.
- Defined: in RUN, if the post-shift mplier==0, go to DONE at that edge. Minimum RUN length is 1 cycle; the result is identical to full iteration. Latency becomes ceil((index of highest set bit of src2 +1)/STEP_BITS), minimum 1.
- Not defined: fixed STEPS-cycle latency, and the mplier zero-detect logic is absent.

Test Plan:
- Accept src1=3, src2=5, id=2, rd=7; resp_ready=1 -> resp_valid exactly 32 cycles after accept, resp_data=15, resp_ovf=0, resp_instr_id=2, resp_rd=7, then IDLE.
- src1=0x0001_0000, src2=0x0001_0000 -> resp_data=0x0000_0000, resp_ovf=1; src1=0xFFFF_FFFF, src2=1 -> resp_data=0xFFFF_FFFF, resp_ovf=0.
- Result ready, resp_ready low for 5 cycles -> resp_valid and resp_data held constant, req_ready=0, busy=1; resp_ready high -> req_ready=1 next cycle.
- flush at RUN cycle 10 -> no resp_valid ever for that op, req_ready=1 next cycle; new request 2*2 completes with 4.
- reset driven low mid-RUN (asynchronously, between edges) -> req_ready=1, busy=0, resp_valid=0 immediately without waiting for a clock edge; after release, normal operation.
- With MUL_EARLY_OUT_EN: 7*1 -> resp_valid 1 cycle after accept, data 7; 7*0 -> 1 cycle, data 0; 2*0x8000_0000 -> 32 cycles, data 0, ovf=1.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier beside the ALU stage.
// Accepts one request at a time, retires STEP_BITS multiplier bits per RUN
// cycle and holds a writeback-ready result (low half + overflow) in DONE.
// Optional macro MUL_EARLY_OUT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero.
module alu_mul_seq #(
    parameter int DATA_W    = 32,
    parameter int ID_W      = 3,
    parameter int STEP_BITS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_instr_id,
    input  logic [4:0]        req_rd,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ID_W-1:0]   resp_instr_id,
    output logic [4:0]        resp_rd,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_ovf,
    output logic              busy
);

    localparam int STEPS = DATA_W / STEP_BITS;
    localparam int PW    = 2 * DATA_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     mcand;
    logic [DATA_W-1:0] mplier;
    logic [PW-1:0]     acc;
    logic [CNT_W-1:0]  count;
    logic [ID_W-1:0]   id_q;
    logic [4:0]        rd_q;

    logic [PW-1:0]     pp;
    logic [DATA_W-1:0] mplier_shr;
    logic              last_step;
    logic              run_end;
    logic              accept;

    // Partial product of the current multiplier digit, kept at full product width.
    assign pp         = mcand * PW'(mplier[STEP_BITS-1:0]);
    assign mplier_shr = mplier >> STEP_BITS;
    assign last_step  = (count == CNT_W'(STEPS - 1));
    assign accept     = (state == IDLE) && req_valid && !flush;

`ifdef MUL_EARLY_OUT_EN
    // Once no multiplier bits remain, further steps would only add zero.
    assign run_end = last_step || (mplier_shr == '0);
`else
    assign run_end = last_step;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)  state_nxt = RUN;
            RUN:     if (run_end)    state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand capture on accept, then one shift-add step per RUN cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            id_q   <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            mcand  <= {{DATA_W{1'b0}}, req_src1};
            mplier <= req_src2;
            acc    <= '0;
            count  <= '0;
            id_q   <= req_instr_id;
            rd_q   <= req_rd;
        end else if (state == RUN) begin
            acc    <= acc + pp;
            mcand  <= mcand << STEP_BITS;
            mplier <= mplier_shr;
            count  <= count + CNT_W'(1);
        end
    end

    // Handshake flags decode straight from the registered state, so there is
    // no req_valid -> req_ready path and no accept in the DONE->IDLE cycle.
    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign resp_valid    = (state == DONE);
    assign resp_instr_id = id_q;
    assign resp_rd       = rd_q;
    assign resp_data     = acc[DATA_W-1:0];
    assign resp_ovf      = |acc[PW-1:DATA_W];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed corners plus randomized
// operands compared against a plain 64-bit multiply reference.
module tb_alu_mul_seq;

    localparam int DATA_W    = 32;
    localparam int ID_W      = 3;
    localparam int STEP_BITS = 1;
    localparam int STEPS     = DATA_W / STEP_BITS;

    logic              clock;
    logic              reset;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_instr_id;
    logic [4:0]        req_rd;
    logic [DATA_W-1:0] req_src1;
    logic [DATA_W-1:0] req_src2;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_instr_id;
    logic [4:0]        resp_rd;
    logic [DATA_W-1:0] resp_data;
    logic              resp_ovf;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_seq #(.DATA_W(DATA_W), .ID_W(ID_W), .STEP_BITS(STEP_BITS)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr_id(req_instr_id), .req_rd(req_rd),
        .req_src1(req_src1), .req_src2(req_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr_id(resp_instr_id), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_ovf(resp_ovf), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from accept to resp_valid, derived from the operand alone.
    function automatic int exp_lat(input logic [DATA_W-1:0] b);
        int h;
        h = -1;
        for (int i = 0; i < DATA_W; i++) if (b[i]) h = i;
`ifdef MUL_EARLY_OUT_EN
        if (h < 0) return 1;
        return (h + STEP_BITS) / STEP_BITS;
`else
        return (h >= DATA_W) ? 0 : STEPS;
`endif
    endfunction

    // One complete operation; hold = extra DONE cycles with resp_ready low.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [ID_W-1:0] id, input logic [4:0] rd, input int hold);
        logic [63:0] prod;
        int lat, guard;
        prod  = {32'b0, a} * {32'b0, b};
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clock); guard++; end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1; req_src1 = a; req_src2 = b; req_instr_id = id; req_rd = rd;
        resp_ready = (hold == 0);
        @(posedge clock);
        @(negedge clock);
        // Junk while busy must be ignored.
        req_src1 = $urandom; req_src2 = $urandom; req_instr_id = ID_W'($urandom); req_rd = 5'($urandom);
        chk("busy_run", busy, 1);
        chk("req_ready_run", req_ready, 0);
        lat = 0;
        while (!resp_valid && lat < 200) begin @(negedge clock); lat++; end
        req_valid = 0;
        chk("latency", lat, exp_lat(b));
        chk("resp_data", resp_data, prod[31:0]);
        chk("resp_ovf", resp_ovf, |prod[63:32]);
        chk("resp_id", resp_instr_id, id);
        chk("resp_rd", resp_rd, rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, prod[31:0]);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_busy", busy, 1);
        end
        resp_ready = 1;
        @(negedge clock);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_busy", busy, 0);
        resp_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int guard, seen;
        reset = 0; flush = 0; req_valid = 0; resp_ready = 0;
        req_instr_id = 0; req_rd = 0; req_src1 = 0; req_src2 = 0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", resp_instr_id, 0);
        chk("rst_rd", resp_rd, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_ovf", resp_ovf, 0);
        reset = 1;
        @(negedge clock);

        // Directed corners.
        do_op(32'd3, 32'd5, 3'd2, 5'd7, 0);
        do_op(32'h0001_0000, 32'h0001_0000, 3'd1, 5'd3, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 3'd4, 5'd9, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 5'd31, 5);
        do_op(32'd7, 32'd1, 3'd6, 5'd1, 0);
        do_op(32'd7, 32'd0, 3'd7, 5'd2, 0);
        do_op(32'd2, 32'h8000_0000, 3'd0, 5'd4, 2);

        // Flush in IDLE beats req_valid.
        req_valid = 1; req_src1 = 9; req_src2 = 9; flush = 1;
        @(negedge clock);
        flush = 0; req_valid = 0;
        chk("flush_idle_busy", busy, 0);
        chk("flush_idle_ready", req_ready, 1);

        // Flush at RUN cycle 10 drops the op.
        req_valid = 1; req_src1 = 9; req_src2 = 32'hFFFF_FFFF; req_instr_id = 3; req_rd = 5;
        @(posedge clock); @(negedge clock);
        req_valid = 0;
        repeat (9) @(negedge clock);
        chk("pre_flush_busy", busy, 1);
        flush = 1;
        @(negedge clock);
        flush = 0;
        chk("flush_run_ready", req_ready, 1);
        chk("flush_run_valid", resp_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clock); seen |= int'(resp_valid); end
        chk("no_resp_after_flush", seen, 0);
        do_op(32'd2, 32'd2, 3'd1, 5'd10, 0);

        // Flush coinciding with resp_ready in DONE.
        req_valid = 1; req_src1 = 6; req_src2 = 7;
        @(posedge clock); @(negedge clock);
        req_valid = 0;
        guard = 0;
        while (!resp_valid && guard < 200) begin @(negedge clock); guard++; end
        chk("done_reached", resp_valid, 1);
        chk("done_data", resp_data, 42);
        flush = 1; resp_ready = 1;
        @(negedge clock);
        flush = 0; resp_ready = 0;
        chk("flush_done_valid", resp_valid, 0);
        chk("flush_done_ready", req_ready, 1);

        // Asynchronous reset in the middle of RUN.
        req_valid = 1; req_src1 = 5; req_src2 = 32'hFFFF_FFFF;
        @(posedge clock); @(negedge clock);
        req_valid = 0;
        repeat (5) @(negedge clock);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 0;
        #1;
        chk("async_rst_ready", req_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", resp_valid, 0);
        chk("async_rst_data", resp_data, 0);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        do_op(32'd11, 32'd13, 3'd2, 5'd6, 1);

        // Randomized operands with varied multiplier lengths and stalls.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
                2: begin a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd0;
                         b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd0; end
                default: begin a = $urandom >> $urandom_range(0, 31); b = $urandom; end
            endcase
            do_op(a, b, ID_W'($urandom), 5'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
